switch_allocator: RTL and testbench

Parametrised switch-allocation stage for the chiplet router. It replaces single-flit, credit-unaware forwarding with per-output wormhole locking, round-robin arbitration across input buffers, and per-VC credit counters. It sits between the input buffers and the output crossbar. Each cycle it grants at most one input per output port and drives the crossbar select and output-valid signals.

---
 rtl/chiplet_types_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/switch_allocator.sv | 156 +++++++++++++++
 tb/tb_switch_allocator.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared chiplet router types: default link geometry, credit/lock types for the
// default configuration, and the per-output wormhole lock state.
package chiplet_types_pkg;

  localparam int NUM_OUTPORTS_DEF = 5;
  localparam int NUM_BUFFERS_DEF  = 5;
  localparam int NUM_VCS_DEF      = 2;
  localparam int BUFFER_DEPTH_DEF = 8;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BUF_W_DEF  = $clog2(NUM_BUFFERS_DEF);
  localparam int VC_W_DEF   = clog2_min1(NUM_VCS_DEF);
  localparam int CRED_W_DEF = $clog2(BUFFER_DEPTH_DEF + 1);

  typedef logic [CRED_W_DEF-1:0] credit_t;

  typedef struct packed {
    logic                 valid;
    logic [BUF_W_DEF-1:0] in;
    logic [VC_W_DEF-1:0]  vc;
  } alloc_lock_t;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter
  import chiplet_types_pkg::*;
#(
  parameter  int N     = 5,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocation stage: per-output wormhole lock, round-robin arbitration over
// input buffers and per-VC downstream credit counters; grants are zero-latency.
module switch_allocator
  import chiplet_types_pkg::*;
#(
  parameter  int NUM_OUTPORTS = 5,
  parameter  int NUM_BUFFERS  = 5,
  parameter  int NUM_VCS      = 2,
  parameter  int BUFFER_DEPTH = 8,
  localparam int OUT_W        = clog2_min1(NUM_OUTPORTS),
  localparam int BUF_W        = $clog2(NUM_BUFFERS),
  localparam int VC_W         = clog2_min1(NUM_VCS),
  localparam int CRED_W       = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_BUFFERS-1:0]                req_valid,
  input  logic [NUM_BUFFERS-1:0][OUT_W-1:0]     req_outport,
  input  logic [NUM_BUFFERS-1:0][VC_W-1:0]      req_vc,
  input  logic [NUM_BUFFERS-1:0]                req_tail,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]  credit_granted,
  output logic [NUM_BUFFERS-1:0]                grant,
  output logic [NUM_OUTPORTS-1:0][BUF_W-1:0]    xbar_sel,
  output logic [NUM_OUTPORTS-1:0]               data_ready_out,
  output logic [NUM_OUTPORTS-1:0]               packet_sent,
  output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]  buffer_available
);

  lock_state_e       lock_state     [NUM_OUTPORTS];
  lock_state_e       lock_state_nxt [NUM_OUTPORTS];
  logic [BUF_W-1:0]  lock_in        [NUM_OUTPORTS];
  logic [BUF_W-1:0]  lock_in_nxt    [NUM_OUTPORTS];
  logic [VC_W-1:0]   lock_vc        [NUM_OUTPORTS];
  logic [VC_W-1:0]   lock_vc_nxt    [NUM_OUTPORTS];
  logic [BUF_W-1:0]  rr_ptr         [NUM_OUTPORTS];
  logic [BUF_W-1:0]  rr_ptr_nxt     [NUM_OUTPORTS];
  logic [CRED_W-1:0] credit         [NUM_OUTPORTS][NUM_VCS];
  logic [CRED_W-1:0] credit_nxt     [NUM_OUTPORTS][NUM_VCS];

  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] cred_dec;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] cred_ovf;

  logic [NUM_BUFFERS-1:0] elig    [NUM_OUTPORTS];
  logic [NUM_BUFFERS-1:0] arb_gnt [NUM_OUTPORTS];
  logic [BUF_W-1:0]       arb_idx [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0] win_valid;
  logic [NUM_OUTPORTS-1:0] win_tail;
  logic [VC_W-1:0]         win_vc [NUM_OUTPORTS];

  // Gating with rst keeps every grant-side output quiet during the reset cycle.
  always_comb begin
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      elig[p] = '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (!rst && req_valid[i] && int'(req_outport[i]) == p && int'(req_vc[i]) < NUM_VCS) begin
          if (credit[p][req_vc[i]] != '0 &&
              (lock_state[p] == LOCK_IDLE ||
               (lock_in[p] == BUF_W'(i) && lock_vc[p] == req_vc[i])))
            elig[p][i] = 1'b1;
        end
      end
    end
  end

  for (genvar gp = 0; gp < NUM_OUTPORTS; gp++) begin : g_out
    rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
      .req     (elig[gp]),
      .ptr     (rr_ptr[gp]),
      .gnt     (arb_gnt[gp]),
      .gnt_idx (arb_idx[gp])
    );

    assign win_valid[gp]      = |arb_gnt[gp];
    assign win_tail[gp]       = req_tail[arb_idx[gp]];
    assign win_vc[gp]         = req_vc[arb_idx[gp]];
    assign xbar_sel[gp]       = arb_idx[gp];
    assign data_ready_out[gp] = win_valid[gp];
    assign packet_sent[gp]    = win_valid[gp] & win_tail[gp];

    for (genvar gv = 0; gv < NUM_VCS; gv++) begin : g_vc
      assign buffer_available[gp][gv] = (credit[gp][gv] != '0);
    end
  end

  always_comb begin
    grant = '0;
    for (int p = 0; p < NUM_OUTPORTS; p++) grant = grant | arb_gnt[p];
  end

  // Lock FSM and pointer: the pointer only moves on a tail grant, once per packet.
  always_comb begin
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      lock_state_nxt[p] = lock_state[p];
      lock_in_nxt[p]    = lock_in[p];
      lock_vc_nxt[p]    = lock_vc[p];
      rr_ptr_nxt[p]     = rr_ptr[p];
      if (win_valid[p]) begin
        if (win_tail[p]) begin
          lock_state_nxt[p] = LOCK_IDLE;
          rr_ptr_nxt[p]     = (arb_idx[p] == BUF_W'(NUM_BUFFERS - 1)) ? '0 : arb_idx[p] + BUF_W'(1);
        end else begin
          lock_state_nxt[p] = LOCK_LOCKED;
          lock_in_nxt[p]    = arb_idx[p];
          lock_vc_nxt[p]    = win_vc[p];
        end
      end
    end
  end

  // A return and a consume on the same counter cancel; a return to a full counter saturates.
  always_comb begin
    for (int p = 0; p < NUM_OUTPORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        cred_dec[p][v]   = win_valid[p] && (int'(win_vc[p]) == v);
        cred_ovf[p][v]   = 1'b0;
        credit_nxt[p][v] = credit[p][v];
        if (credit_granted[p][v] && !cred_dec[p][v]) begin
          if (credit[p][v] == CRED_W'(BUFFER_DEPTH)) cred_ovf[p][v]   = 1'b1;
          else                                      credit_nxt[p][v] = credit[p][v] + CRED_W'(1);
        end else if (cred_dec[p][v] && !credit_granted[p][v]) begin
          credit_nxt[p][v] = credit[p][v] - CRED_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        lock_state[p] <= LOCK_IDLE;
        lock_in[p]    <= '0;
        lock_vc[p]    <= '0;
        rr_ptr[p]     <= '0;
        // NOTE: the credit array is real state visible downstream, so unlike a data memory it is reset.
        for (int v = 0; v < NUM_VCS; v++) credit[p][v] <= CRED_W'(BUFFER_DEPTH);
      end
    end else begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
        lock_state[p] <= lock_state_nxt[p];
        lock_in[p]    <= lock_in_nxt[p];
        lock_vc[p]    <= lock_vc_nxt[p];
        rr_ptr[p]     <= rr_ptr_nxt[p];
        for (int v = 0; v < NUM_VCS; v++) credit[p][v] <= credit_nxt[p][v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_overflow: assert (cred_ovf == '0)
        else $warning("credit_overflow: credit returned to a full counter (%b)", cred_ovf);
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus random traffic,
// all compared cycle by cycle against a rule-level reference model.
module tb_switch_allocator;

  localparam int NO    = 5;
  localparam int NB    = 5;
  localparam int NV    = 2;
  localparam int DEPTH = 8;
  localparam int OW    = 3;
  localparam int BW    = 3;
  localparam int VW    = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NB-1:0]          req_valid;
  logic [NB-1:0][OW-1:0]  req_outport;
  logic [NB-1:0][VW-1:0]  req_vc;
  logic [NB-1:0]          req_tail;
  logic [NO-1:0][NV-1:0]  credit_granted;
  logic [NB-1:0]          grant;
  logic [NO-1:0][BW-1:0]  xbar_sel;
  logic [NO-1:0]          data_ready_out;
  logic [NO-1:0]          packet_sent;
  logic [NO-1:0][NV-1:0]  buffer_available;

  always #5 clk = ~clk;

  switch_allocator #(
    .NUM_OUTPORTS (NO),
    .NUM_BUFFERS  (NB),
    .NUM_VCS      (NV),
    .BUFFER_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_outport      (req_outport),
    .req_vc           (req_vc),
    .req_tail         (req_tail),
    .credit_granted   (credit_granted),
    .grant            (grant),
    .xbar_sel         (xbar_sel),
    .data_ready_out   (data_ready_out),
    .packet_sent      (packet_sent),
    .buffer_available (buffer_available)
  );

  typedef logic [39:0] obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, kept as plain integers.
  int m_credit [NO][NV];
  bit m_lock   [NO];
  int m_lock_in[NO];
  int m_lock_vc[NO];
  int m_ptr    [NO];
  int m_win    [NO];

  logic [NB-1:0]         e_grant, c_grant;
  logic [NO-1:0][BW-1:0] e_xbar, c_xbar;
  logic [NO-1:0]         e_dro, c_dro, e_ps, c_ps;
  logic [NO-1:0][NV-1:0] e_ba, c_ba;
  obs_t                  obs, exp_o;

  task automatic model_eval();
    e_grant = '0; e_xbar = '0; e_dro = '0; e_ps = '0; e_ba = '0;
    for (int p = 0; p < NO; p++) begin
      m_win[p] = -1;
      for (int v = 0; v < NV; v++) e_ba[p][v] = (m_credit[p][v] > 0);
      if (!rst) begin
        for (int k = 0; k < NB; k++) begin
          int i;
          i = (m_ptr[p] + k) % NB;
          if (m_win[p] < 0 && req_valid[i] && int'(req_outport[i]) == p &&
              m_credit[p][int'(req_vc[i])] > 0 &&
              (!m_lock[p] || (i == m_lock_in[p] && int'(req_vc[i]) == m_lock_vc[p])))
            m_win[p] = i;
        end
        if (m_win[p] >= 0) begin
          e_grant[m_win[p]] = 1'b1;
          e_xbar[p]         = 3'(m_win[p]);
          e_dro[p]          = 1'b1;
          e_ps[p]           = req_tail[m_win[p]];
        end
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      for (int p = 0; p < NO; p++) begin
        m_lock[p] = 1'b0;
        m_ptr[p]  = 0;
        for (int v = 0; v < NV; v++) m_credit[p][v] = DEPTH;
      end
    end else begin
      for (int p = 0; p < NO; p++) begin
        int w;
        w = m_win[p];
        for (int v = 0; v < NV; v++) begin
          bit inc, dec;
          inc = credit_granted[p][v];
          dec = (w >= 0) && (int'(req_vc[w]) == v);
          if (inc && !dec)      m_credit[p][v] = (m_credit[p][v] < DEPTH) ? m_credit[p][v] + 1 : DEPTH;
          else if (dec && !inc) m_credit[p][v] = m_credit[p][v] - 1;
        end
        if (w >= 0) begin
          if (req_tail[w]) begin
            m_lock[p] = 1'b0;
            m_ptr[p]  = (w + 1) % NB;
          end else begin
            m_lock[p]    = 1'b1;
            m_lock_in[p] = w;
            m_lock_vc[p] = int'(req_vc[w]);
          end
        end
      end
    end
  endtask

  // Sample outputs mid-cycle, then advance the model together with the DUT edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    c_grant = grant; c_xbar = xbar_sel; c_dro = data_ready_out;
    c_ps = packet_sent; c_ba = buffer_available;
    obs   = {c_grant, c_xbar, c_dro, c_ps, c_ba};
    exp_o = {e_grant, e_xbar, e_dro, e_ps, e_ba};
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_outport = '0; req_vc = '0; req_tail = '0; credit_granted = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NB; i++) begin
      req_valid[i]   = 1'($urandom_range(0, 1));
      req_outport[i] = 3'($urandom_range(0, 7));
      req_vc[i]      = 1'($urandom_range(0, 1));
      req_tail[i]    = ($urandom_range(0, 2) != 0);
    end
    for (int p = 0; p < NO; p++)
      for (int v = 0; v < NV; v++)
        credit_granted[p][v] = (m_credit[p][v] < DEPTH) && ($urandom_range(0, 3) == 0);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    rand_inputs();
    credit_granted = '0;
    cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL reset_cycle: got %h want %h", obs, exp_o); end
    n_cmp++;
    if (c_grant !== '0 || c_ba !== '1) begin
      n_bad++; $display("FAIL reset_outputs: grant %b ba %b want grant 0 ba all ones", c_grant, c_ba);
    end
    rst = 1'b0;
    clear_inputs();
    cycle();
    n_cmp++;
    if (c_ba !== '1) begin n_bad++; $display("FAIL reset_credit_visible: got %b want all ones", c_ba); end
  endtask

  task automatic test_credit_exhaust();
    int gcount;
    gcount = 0;
    clear_inputs();
    req_valid[0] = 1'b1; req_outport[0] = 3'd1; req_vc[0] = 1'b0; req_tail[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL exhaust cycle %0d: got %h want %h", k, obs, exp_o); end
      if (c_grant[0]) gcount++;
    end
    n_cmp++;
    if (gcount !== 8) begin n_bad++; $display("FAIL exhaust_grant_count: got %0d want 8", gcount); end
    n_cmp++;
    if (c_ba[1] !== 2'b10) begin n_bad++; $display("FAIL exhaust_available: got %b want 10", c_ba[1]); end
    clear_inputs();
    credit_granted[1][0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL refill cycle %0d: got %h want %h", k, obs, exp_o); end
    end
    clear_inputs();
    cycle();
    n_cmp++;
    if (c_ba[1] !== 2'b11) begin n_bad++; $display("FAIL refill_available: got %b want 11", c_ba[1]); end
  endtask

  task automatic test_wormhole();
    logic [NB-1:0] want_g [4];
    logic          want_ps[4];
    want_g  = '{5'b00100, 5'b00100, 5'b00100, 5'b10000};
    want_ps = '{1'b0, 1'b0, 1'b1, 1'b1};
    clear_inputs();
    req_valid[2] = 1'b1; req_outport[2] = 3'd0; req_vc[2] = 1'b0;
    req_valid[4] = 1'b1; req_outport[4] = 3'd0; req_vc[4] = 1'b1; req_tail[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_tail[2]  = (k == 2);
      req_valid[2] = (k < 3);
      cycle();
      n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL wormhole cycle %0d: got %h want %h", k, obs, exp_o); end
      n_cmp++;
      if (c_grant !== want_g[k] || c_ps[0] !== want_ps[k]) begin
        n_bad++;
        $display("FAIL wormhole_order cycle %0d: grant %b sent %b want grant %b sent %b",
                 k, c_grant, c_ps[0], want_g[k], want_ps[k]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int want [6];
    want = '{0, 1, 3, 0, 1, 3};
    clear_inputs();
    for (int i = 0; i < NB; i++) begin
      if (i != 2 && i != 4) begin
        req_valid[i] = 1'b1; req_outport[i] = 3'd2; req_tail[i] = 1'b1;
      end
    end
    credit_granted[2][0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL round_robin cycle %0d: got %h want %h", k, obs, exp_o); end
      n_cmp++;
      if (c_grant !== (5'b00001 << want[k]) || int'(c_xbar[2]) != want[k]) begin
        n_bad++;
        $display("FAIL round_robin_order cycle %0d: grant %b sel %0d want input %0d", k, c_grant, c_xbar[2], want[k]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_credit_events();
    int gcount;
    clear_inputs();
    req_valid[3] = 1'b1; req_outport[3] = 3'd1; req_vc[3] = 1'b1; req_tail[3] = 1'b1;
    cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL credit_consume: got %h want %h", obs, exp_o); end
    credit_granted[1][1] = 1'b1;
    cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL credit_simultaneous: got %h want %h", obs, exp_o); end
    credit_granted = '0;
    gcount = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL credit_drain cycle %0d: got %h want %h", k, obs, exp_o); end
      if (c_grant[3]) gcount++;
    end
    n_cmp++;
    if (gcount !== 7) begin n_bad++; $display("FAIL credit_unchanged_count: got %0d want 7", gcount); end
    clear_inputs();
    credit_granted[1][1] = 1'b1;
    for (int k = 0; k < 9; k++) cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL credit_saturate: got %h want %h", obs, exp_o); end
    clear_inputs();
    req_valid[3] = 1'b1; req_outport[3] = 3'd1; req_vc[3] = 1'b1; req_tail[3] = 1'b1;
    gcount = 0;
    for (int k = 0; k < 9; k++) begin
      cycle();
      if (c_grant[3]) gcount++;
    end
    n_cmp++;
    if (gcount !== 8) begin n_bad++; $display("FAIL credit_saturate_count: got %0d want 8", gcount); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    clear_inputs();
    req_valid[1] = 1'b1; req_outport[1] = 3'd3;
    cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL midpkt_lock: got %h want %h", obs, exp_o); end
    req_valid[0] = 1'b1; req_outport[0] = 3'd3;
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (c_grant !== '0 || c_dro !== '0 || c_xbar !== '0) begin
      n_bad++; $display("FAIL midpkt_reset_quiet: grant %b ready %b sel %h want all zero", c_grant, c_dro, c_xbar);
    end
    rst = 1'b0;
    req_tail[0] = 1'b1;
    cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL midpkt_after: got %h want %h", obs, exp_o); end
    n_cmp++;
    if (c_grant !== 5'b00001 || c_xbar[3] !== 3'd0 || c_ba !== '1) begin
      n_bad++; $display("FAIL midpkt_head: grant %b sel %0d ba %b want 00001 0 all ones", c_grant, c_xbar[3], c_ba);
    end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b1; req_outport[i] = 3'(i); req_tail[i] = 1'b1;
    end
    cycle();
    n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL concurrent: got %h want %h", obs, exp_o); end
    n_cmp++;
    if (c_grant !== 5'b00111 || c_dro !== 5'b00111 ||
        c_xbar[0] !== 3'd0 || c_xbar[1] !== 3'd1 || c_xbar[2] !== 3'd2) begin
      n_bad++; $display("FAIL concurrent_sel: grant %b ready %b sel %h", c_grant, c_dro, c_xbar);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      n_cmp++;
      if (obs !== exp_o) begin n_bad++; $display("FAIL random cycle %0d: got %h want %h", k, obs, exp_o); end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    for (int p = 0; p < NO; p++) begin
      m_lock[p] = 1'b0; m_lock_in[p] = 0; m_lock_vc[p] = 0; m_ptr[p] = 0; m_win[p] = -1;
      for (int v = 0; v < NV; v++) m_credit[p][v] = DEPTH;
    end
    rst = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_credit_exhaust();
    test_wormhole();
    test_round_robin();
    test_credit_events();
    test_reset_mid_packet();
    test_concurrent();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
